// File: rtl/echo_cancel_scheduler_if.sv
// Start/done handshake bundle between the frame scheduler and its four datapath engines.
interface echo_cancel_scheduler_if;
  logic conv_start;
  logic conv_done;
  logic adapt_start;
  logic adapt_done;
  logic cancel_start;
  logic cancel_done;
  logic out_start;
  logic out_done;

  modport master (
    output conv_start, adapt_start, cancel_start, out_start,
    input  conv_done, adapt_done, cancel_done, out_done
  );

  modport slave (
    input  conv_start, adapt_start, cancel_start, out_start,
    output conv_done, adapt_done, cancel_done, out_done
  );
endinterface

// File: rtl/echo_cancel_scheduler.sv
// Per-frame sequencer stepping each channel through convert/adapt/cancel/output
// using start/done handshakes, with a per-stage watchdog and sticky error flags.
module echo_cancel_scheduler #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 13,
  parameter int ITER_W  = 13,
  parameter int TIMEOUT = 1023,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WD_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk_operation,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      sampling_cycle_counter,
  input  logic [ITER_W-1:0]     set_max_iteration,
  input  logic [1:0]            mode,
  input  logic                  err_clr,
  echo_cancel_scheduler_if.master hs,
  output logic [CH_W-1:0]       ch_sel,
  output logic [1:0]            out_sel,
  output logic                  adapting,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ITER_W-1:0]     iteration,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  typedef enum logic [2:0] {IDLE, CONV, ADAPT, CANCEL, OUTPUT, NEXT} state_t;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_FORCE  = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  state_t          state;
  state_t          adv_state;
  logic [1:0]      mode_q;
  logic            stage_first;
  logic [WD_W-1:0] wdog;
  logic            conv_start_q, adapt_start_q, cancel_start_q, out_start_q;
  logic            trigger, last_ch, adapt_now, stage_done;

  assign hs.conv_start   = conv_start_q;
  assign hs.adapt_start  = adapt_start_q;
  assign hs.cancel_start = cancel_start_q;
  assign hs.out_start    = out_start_q;
  assign busy            = (state != IDLE);

  // Stage routing depends only on the mode and adapt decision latched at trigger.
  always_comb begin
    trigger    = enable && (sampling_cycle_counter == '0);
    last_ch    = (ch_sel == CH_W'(NUM_CH - 1));
    adapt_now  = (mode == MODE_FORCE) ||
                 ((mode == MODE_AUTO) && (iteration < set_max_iteration));
    stage_done = 1'b0;
    adv_state  = IDLE;
    case (state)
      CONV: begin
        stage_done = hs.conv_done;
        adv_state  = (mode_q == MODE_BYPASS) ? OUTPUT : (adapting ? ADAPT : CANCEL);
      end
      ADAPT: begin
        stage_done = hs.adapt_done;
        adv_state  = CANCEL;
      end
      CANCEL: begin
        stage_done = hs.cancel_done;
        adv_state  = OUTPUT;
      end
      OUTPUT: begin
        stage_done = hs.out_done;
        adv_state  = NEXT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= MODE_AUTO;
      stage_first    <= 1'b0;
      wdog           <= '0;
      conv_start_q   <= 1'b0;
      adapt_start_q  <= 1'b0;
      cancel_start_q <= 1'b0;
      out_start_q    <= 1'b0;
      ch_sel         <= '0;
      out_sel        <= 2'd0;
      adapting       <= 1'b0;
      frame_done     <= 1'b0;
      iteration      <= '0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      conv_start_q   <= 1'b0;
      adapt_start_q  <= 1'b0;
      cancel_start_q <= 1'b0;
      out_start_q    <= 1'b0;
      frame_done     <= 1'b0;
      // Clears come first so a simultaneous error event overrides them.
      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (trigger && (state != IDLE))
        overrun_err <= 1'b1;
      case (state)
        IDLE: begin
          if (trigger) begin
            state        <= CONV;
            conv_start_q <= 1'b1;
            stage_first  <= 1'b1;
            wdog         <= '0;
            ch_sel       <= '0;
            mode_q       <= mode;
            adapting     <= adapt_now;
            out_sel      <= adapt_now ? 2'd0 : ((mode == MODE_BYPASS) ? 2'd2 : 2'd1);
          end
        end
        CONV, ADAPT, CANCEL, OUTPUT: begin
          // A done seen during the start cycle belongs to a previous request.
          if (!stage_first && stage_done) begin
            state          <= adv_state;
            stage_first    <= (adv_state != NEXT);
            wdog           <= '0;
            adapt_start_q  <= (adv_state == ADAPT);
            cancel_start_q <= (adv_state == CANCEL);
            out_start_q    <= (adv_state == OUTPUT);
            if ((state == OUTPUT) && last_ch) begin
              frame_done <= 1'b1;
              if (adapting && (iteration != '1))
                iteration <= iteration + ITER_W'(1);
            end
          end else if (!stage_first && (wdog == WD_W'(TIMEOUT))) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            stage_first <= 1'b0;
            adapting    <= 1'b0;
            ch_sel      <= '0;
          end else begin
            stage_first <= 1'b0;
            wdog        <= wdog + WD_W'(1);
          end
        end
        NEXT: begin
          if (!last_ch) begin
            ch_sel       <= ch_sel + CH_W'(1);
            state        <= CONV;
            conv_start_q <= 1'b1;
            stage_first  <= 1'b1;
            wdog         <= '0;
          end else begin
            state    <= IDLE;
            ch_sel   <= '0;
            adapting <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/echo_cancel_scheduler.md
Name: echo_cancel_scheduler

Overview:
Handshake-driven frame sequencer for the echo-cancellation datapath, parametrised in channel count and timing. Once per sampling frame it steps each channel through convert -> adapt -> cancel -> output, using start/done handshakes instead of fixed delays. It supports auto/forced-adapt/freeze/bypass modes, a saturating iteration counter, per-stage watchdog timeouts and frame-overrun detection. It sits above the 16b<->double converters, parameter-approximation and cancellation engines.

Parameters:
NUM_CH, 2, number of channels processed sequentially per frame (1..16)
CNT_W, 13, width of sampling_cycle_counter
ITER_W, 13, width of iteration / set_max_iteration
TIMEOUT, 1023, max cycles a stage may wait for its done before abort (>=2)

Ports:
clk_operation  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  frame-trigger qualifier
sampling_cycle_counter  in  CNT_W  frame position; ==0 marks frame start
set_max_iteration  in  ITER_W  adapt-frame limit in auto mode
mode  in  2  00 auto, 01 force adapt, 10 freeze (cancel only), 11 bypass
err_clr  in  1  clears sticky error flags
conv_start / conv_done  out / in  1 / 1  converter handshake
adapt_start / adapt_done  out / in  1 / 1  parameter-approximation handshake
cancel_start / cancel_done  out / in  1 / 1  cancellation handshake
out_start / out_done  out / in  1 / 1  double->16b output handshake
ch_sel  out  max(1,clog2(NUM_CH))  channel currently being processed
out_sel  out  2  output source: 0 error e, 1 echo-cancelled, 2 raw; 3 unused
adapting  out  1  current frame is an adapt frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after last channel's output accepted
iteration  out  ITER_W  adapt frames completed, saturating
timeout_err  out  1  sticky; stage exceeded TIMEOUT
overrun_err  out  1  sticky; trigger arrived while busy

Behaviour:
- Reset: state IDLE; all start pulses, frame_done, busy, adapting, ch_sel, out_sel, iteration, timeout_err, overrun_err = 0. rst mid-frame aborts at that edge; no pulse is emitted afterwards.
- Trigger: in IDLE, enable=1 and sampling_cycle_counter==0 sampled at an edge -> next cycle enter CONV, ch_sel=0, conv_start=1. adapting is latched at trigger and held for the frame: 1 if mode==01, or mode==00 and iteration < set_max_iteration; else 0. mode is also latched at trigger.
- States: IDLE, CONV, ADAPT, CANCEL, OUTPUT, NEXT.
- Paths:
  - adapt frame: CONV -> ADAPT -> CANCEL -> OUTPUT, out_sel=0.
  - freeze, or auto with no adapt: CONV -> CANCEL -> OUTPUT, out_sel=1.
  - bypass: CONV -> OUTPUT, out_sel=2.
- Handshake: start is a one-cycle pulse on the first cycle of a stage. done is accepted from the cycle after start onward; done coincident with start is ignored. When done is accepted, the next stage's start is asserted the following cycle (1-cycle transition latency).
- OUTPUT done -> NEXT (1 cycle). If ch_sel < NUM_CH-1: increment ch_sel and enter CONV. Else: pulse frame_done, increment iteration if adapting (saturate at all-ones), return to IDLE, ch_sel=0.
- Watchdog: counter cleared at every start and incremented each waiting cycle. If it reaches TIMEOUT with done low: set timeout_err, abort to IDLE with no frame_done and no iteration increment. done on the cycle the count reaches TIMEOUT is accepted.
- Overrun: a trigger condition while busy sets overrun_err and is otherwise ignored; the current frame continues.
- Error flags: err_clr clears both flags. An error event in the same cycle as err_clr wins (flag = 1).
- enable dropped mid-frame: the current frame completes; no new triggers.
- set_max_iteration=0 in auto mode: no frame adapts.
- Back-to-back: from IDLE, a trigger in the cycle immediately after frame_done is accepted.

Test Plan:
- NUM_CH=2, mode=00, set_max_iteration=3, all done inputs returned 5 cycles after start -> frames 1-3 run CONV/ADAPT/CANCEL/OUTPUT per channel with out_sel=0; iteration=1,2,3; frame 4 skips ADAPT with out_sel=1, iteration stays 3.
- mode=11 -> only conv_start/out_start pulse for ch 0 then ch 1, out_sel=2, adapting=0; frame_done 1 cycle after second out_done accepted.
- Withhold adapt_done, TIMEOUT=1023 -> timeout_err=1 at the 1023rd wait cycle, busy=0 next cycle, no frame_done, iteration unchanged; err_clr -> flag 0.
- Trigger (counter=0) while in CANCEL -> overrun_err=1, frame completes normally with exactly one frame_done.
- Assert rst mid-ADAPT -> next cycle all outputs 0, iteration 0, state IDLE; done held high after reset produces no start pulses.
- done held high during the start cycle and afterwards -> accepted on the following cycle only; iteration saturates at 8191 when set_max_iteration=8191 and mode=01.
